uart_rx_fifo: RTL

- Receive buffer between the UART receiver and the CPU's memory-mapped I/O read path.
- Captures each byte the UART delivers and holds it in a DEPTH-entry circular FIFO.
- CPU pops bytes by loading from the data address and reads fill/overflow state from the status address.
- Raises an interrupt request once the fill level reaches a programmable threshold, so software is not forced to service every byte immediately.

---
 rtl/uart_rx_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the CPU I/O read path.
// Captures one byte per rx_flag rising edge; the CPU pops via DATA_ADDR and controls via STAT_ADDR.
module uart_rx_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  DATA_ADDR = 8'd252,
    parameter logic [7:0]  STAT_ADDR = 8'd248,
    parameter int          IRQ_LEVEL = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_flag,
    input  logic [7:0]                 access_addr,
    input  logic                       reg_w_en,
    input  logic                       mem_w_en,
    input  logic [7:0]                 w_data,
    output logic [7:0]                 fifo_data,
    output logic [7:0]                 fifo_status,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       int_req
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          rx_flag_q;

    logic          push_edge, pop_req, ctrl_wr, flush, clr_ovf;
    logic          push_ok, pop_ok, drop;
    logic          not_empty, full, irq_pending;
    logic [CW-1:0] next_count;
    logic [AW-1:0] next_wr_ptr, next_rd_ptr;
    logic          next_overflow;
    logic          unused_bits;

    assign unused_bits = ^w_data[6:1];

    always_comb begin
        not_empty   = (count != '0);
        full        = (count == CW'(DEPTH));
        irq_pending = (count >= CW'(IRQ_LEVEL));

        push_edge = rx_flag & ~rx_flag_q;
        pop_req   = reg_w_en & (access_addr == DATA_ADDR) & not_empty;
        ctrl_wr   = mem_w_en & (access_addr == STAT_ADDR);
        flush     = ctrl_wr & w_data[0];
        clr_ovf   = ctrl_wr & w_data[7];

        // A push into a full FIFO only fits when a pop frees the head in the same cycle.
        pop_ok  = pop_req & ~flush;
        push_ok = push_edge & ~flush & (~full | pop_req);
        drop    = push_edge & ~flush & full & ~pop_req;

        next_wr_ptr   = push_ok ? wr_ptr + 1'b1 : wr_ptr;
        next_rd_ptr   = flush ? wr_ptr : (pop_ok ? rd_ptr + 1'b1 : rd_ptr);
        next_count    = flush ? '0 : count + CW'(push_ok) - CW'(pop_ok);
        next_overflow = clr_ovf ? 1'b0 : (drop ? 1'b1 : overflow);

        fifo_data   = not_empty ? mem[rd_ptr] : 8'h00;
        fifo_status = {overflow, full, 3'b000, irq_pending, 1'b0, not_empty};
        fifo_count  = count;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            // Held high so a flag already asserted at reset release is not seen as an edge.
            rx_flag_q <= 1'b1;
            int_req   <= 1'b0;
        end else begin
            wr_ptr    <= next_wr_ptr;
            rd_ptr    <= next_rd_ptr;
            count     <= next_count;
            overflow  <= next_overflow;
            rx_flag_q <= rx_flag;
            int_req   <= (next_count >= CW'(IRQ_LEVEL));
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end
endmodule
